// File: rtl/fn_sw_arb.sv
// fn_sw_arb: two-requester round-robin arbiter sharing one XOR/AND unit over EXEC_CYC cycles.
// Define FN_SW_ARB_FIXED_PRIO_EN to make requester 0 always win simultaneous requests.
module fn_sw_arb #(
   parameter int EXEC_CYC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic a0,
   input  logic b0,
   input  logic sel0,
   input  logic req1,
   input  logic a1,
   input  logic b1,
   input  logic sel1,
   output logic gnt0,
   output logic gnt1,
   output logic y,
   output logic y_vld,
   output logic y_id,
   output logic busy
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic a_q, a_d, b_q, b_d, sel_q, sel_d, id_q, id_d;
   logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic win;
`ifdef FN_SW_ARB_FIXED_PRIO_EN
   assign win = !req0;
`else
   // last_q resets to 1 so requester 0 is favoured first
   logic last_q;
   assign win = (req0 && req1) ? !last_q : req1;
   always_ff @(posedge clk)
      if (rst) last_q <= 1'b1;
      else if (state_q == DONE) last_q <= id_q;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      a_d = a_q;
      b_d = b_q;
      sel_d = sel_q;
      id_d = id_q;
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
      case (state_q)
         IDLE: if (req0 || req1) begin
            state_d = EXEC;
            cnt_d = '0;
            id_d = win;
            a_d = win ? a1 : a0;
            b_d = win ? b1 : b0;
            sel_d = win ? sel1 : sel0;
            gnt0_d = !win;
            gnt1_d = win;
         end
         EXEC: begin
            state_d = (cnt_q == 4'(EXEC_CYC - 1)) ? DONE : EXEC;
            cnt_d = (cnt_q == 4'(EXEC_CYC - 1)) ? '0 : cnt_q + 4'd1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         {a_q, b_q, sel_q, id_q} <= '0;
         {gnt0_q, gnt1_q} <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         {a_q, b_q, sel_q, id_q} <= {a_d, b_d, sel_d, id_d};
         {gnt0_q, gnt1_q} <= {gnt0_d, gnt1_d};
      end
   assign gnt0 = gnt0_q;
   assign gnt1 = gnt1_q;
   assign y_vld = (state_q == DONE);
   assign y = y_vld & (sel_q ? (a_q ^ b_q) : (a_q & b_q));
   assign y_id = y_vld & id_q;
   assign busy = (state_q != IDLE);
endmodule
